playback_scheduler: RTL and testbench

- Top-level playback sequencer for the frame-streaming path.
- Paces video frame advances off display vsync and manages ping-pong video banks: the SPI data FSM writes one bank while the display reads the other.
- Issues one-cycle fetch requests to the SPI data FSM whenever the write bank is free. Starts, stops and faults playback.
- Sits between the start button/VGA timing and the SPI data FSM / video memory banks.

---
 rtl/playback_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_playback_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playback_scheduler.sv
// ---------------------------------------------------------------------------
// playback_scheduler
//
// Top-level playback sequencer for the frame-streaming path. It paces video
// frame advances off display vsync and manages two ping-pong video banks:
// the SPI data FSM fills bank wr_sel while the display reads bank rd_sel.
// A one-cycle fetch request is issued whenever the write bank is free.
// A watchdog faults playback if a fetch stays outstanding too long.
//
// States: IDLE -> PRIME (fill both banks) -> PLAY (paced advances) and
// FAULT (fetch timeout). stop returns to IDLE from anywhere.
//
// Optional build macro: LOOP_PLAYBACK_EN
//   defined   : the end-of-stream advance wraps frame_count to 0 and playback
//               continues in PLAY.
//   undefined : the end-of-stream advance point returns to IDLE instead.
//
// Ports:
//   CLK_40        in   system clock, 40 MHz
//   reset         in   synchronous, active-high
//   start         in   debounced button level (rising edge used)
//   stop          in   level, forces return to IDLE
//   vsync_pulse   in   one-cycle pulse per display frame
//   fetch_done    in   one-cycle pulse: outstanding fetch has completed
//   fetch_req     out  one-cycle pulse requesting a fetch into bank wr_sel
//   wr_sel        out  bank targeted by fetches
//   rd_sel        out  bank currently displayed
//   bank_valid    out  per-bank "holds an undisplayed or displaying frame"
//   frame_advance out  one-cycle pulse when rd_sel switches
//   underrun      out  one-cycle pulse: advance due but next bank not valid
//   frame_count   out  index of the displayed frame
//   playing       out  high in PLAY
//   fault         out  high in FAULT
// ---------------------------------------------------------------------------
module playback_scheduler #(
  parameter int FRAME_REPEAT   = 2,
  parameter int NUM_FRAMES     = 6572,
  parameter int FRAME_CNT_W    = 13,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                   CLK_40,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   vsync_pulse,
  input  logic                   fetch_done,
  output logic                   fetch_req,
  output logic                   wr_sel,
  output logic                   rd_sel,
  output logic [1:0]             bank_valid,
  output logic                   frame_advance,
  output logic                   underrun,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   playing,
  output logic                   fault
);

  localparam int DIV_W  = (FRAME_REPEAT > 1) ? $clog2(FRAME_REPEAT) : 1;
  localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [DIV_W-1:0]       DIV_LAST   = DIV_W'(FRAME_REPEAT - 1);
  localparam logic [WDOG_W-1:0]      WDOG_LAST  = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_PLAY  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t                   r_state;
  logic                     r_start_d;
  logic [DIV_W-1:0]         r_div;
  logic [WDOG_W-1:0]        r_wdog;
  logic                     r_fetch_busy;
  logic [1:0]               r_bank_valid;
  logic                     r_wr_sel;
  logic                     r_rd_sel;
  logic [FRAME_CNT_W-1:0]   r_frame_count;
  logic                     r_fetch_req;
  logic                     r_frame_advance;
  logic                     r_underrun;
  logic                     r_playing;
  logic                     r_fault;

  logic                     w_start_rise;
  logic                     w_active;
  logic                     w_fetch_accept;
  logic                     w_fetch_issue;
  logic                     w_timeout;
  logic                     w_adv_point;
  logic                     w_next_ready;
  logic                     w_adv;
  logic                     w_eos;
  logic                     w_eos_stop;
  logic                     w_underrun;
  logic                     w_play_entry;
  logic                     w_go_idle;
  logic [1:0]               w_bv_next;

  // Decode of the current cycle's events from registered state and inputs.
  always_comb begin
    w_start_rise   = start & ~r_start_d;
    w_active       = (r_state == S_PRIME) || (r_state == S_PLAY);
    w_fetch_accept = w_active & r_fetch_busy & fetch_done;
    w_fetch_issue  = w_active & ~r_fetch_busy & ~r_bank_valid[r_wr_sel];
    w_timeout      = w_active & r_fetch_busy & (r_wdog == WDOG_LAST);
    // A timeout takes precedence over any advance/underrun in the same cycle.
    w_adv_point    = (r_state == S_PLAY) & vsync_pulse & (r_div == DIV_LAST) & ~w_timeout;
    // Decision uses pre-update bank_valid, so a fetch completing on the
    // advance-point cycle still produces an underrun.
    w_next_ready   = r_bank_valid[~r_rd_sel];
    w_adv          = w_adv_point & w_next_ready;
    w_underrun     = w_adv_point & ~w_next_ready;
    w_eos          = w_adv & (r_frame_count == FRAME_LAST);
`ifdef LOOP_PLAYBACK_EN
    w_eos_stop     = 1'b0;
`else
    w_eos_stop     = w_eos;
`endif
    w_play_entry   = (r_state == S_PRIME) & vsync_pulse & (r_bank_valid == 2'b11) & ~w_timeout;
    w_go_idle      = stop | ((r_state == S_FAULT) & w_start_rise) | w_eos_stop;

    // Fill and release touch different banks while playing (wr_sel != rd_sel
    // whenever a fetch is outstanding).
    w_bv_next = r_bank_valid;
    if (w_fetch_accept) w_bv_next[r_wr_sel] = 1'b1;
    if (w_adv)          w_bv_next[r_rd_sel] = 1'b0;
  end

  always_ff @(posedge CLK_40) begin
    r_fetch_req     <= 1'b0;
    r_frame_advance <= 1'b0;
    r_underrun      <= 1'b0;
    if (reset) begin
      r_start_d     <= 1'b0;
      r_state       <= S_IDLE;
      r_div         <= '0;
      r_wdog        <= '0;
      r_fetch_busy  <= 1'b0;
      r_bank_valid  <= 2'b00;
      r_wr_sel      <= 1'b0;
      r_rd_sel      <= 1'b0;
      r_frame_count <= '0;
      r_playing     <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_start_d <= start;
      if (w_go_idle) begin
        // IDLE entry abandons any outstanding fetch and empties both banks.
        r_state       <= S_IDLE;
        r_div         <= '0;
        r_wdog        <= '0;
        r_fetch_busy  <= 1'b0;
        r_bank_valid  <= 2'b00;
        r_wr_sel      <= 1'b0;
        r_rd_sel      <= 1'b0;
        r_frame_count <= '0;
        r_playing     <= 1'b0;
        r_fault       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_rise) r_state <= S_PRIME;
          end
          S_FAULT: begin
            // Frozen: fetch_busy and bank_valid keep their values until
            // the operator restarts.
          end
          default: begin
            if (w_timeout) begin
              r_state   <= S_FAULT;
              r_fault   <= 1'b1;
              r_playing <= 1'b0;
              r_wdog    <= '0;
            end else begin
              r_bank_valid <= w_bv_next;

              // Fetch engine: complete, or issue a new request one cycle
              // after the bank flip at the earliest.
              if (w_fetch_accept) begin
                r_wr_sel     <= ~r_wr_sel;
                r_fetch_busy <= 1'b0;
              end else if (w_fetch_issue) begin
                r_fetch_req  <= 1'b1;
                r_fetch_busy <= 1'b1;
              end

              if (r_fetch_busy && !w_fetch_accept) r_wdog <= r_wdog + 1'b1;
              else                                 r_wdog <= '0;

              if (w_play_entry) begin
                r_state       <= S_PLAY;
                r_playing     <= 1'b1;
                r_div         <= '0;
                r_rd_sel      <= 1'b0;
                r_frame_count <= '0;
              end

              if ((r_state == S_PLAY) && vsync_pulse) begin
                if (r_div == DIV_LAST) r_div <= '0;
                else                   r_div <= r_div + 1'b1;
              end

              if (w_adv) begin
                r_rd_sel        <= ~r_rd_sel;
                r_frame_advance <= 1'b1;
                if (w_eos) r_frame_count <= '0;
                else       r_frame_count <= r_frame_count + 1'b1;
              end

              if (w_underrun) r_underrun <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign fetch_req     = r_fetch_req;
  assign wr_sel        = r_wr_sel;
  assign rd_sel        = r_rd_sel;
  assign bank_valid    = r_bank_valid;
  assign frame_advance = r_frame_advance;
  assign underrun      = r_underrun;
  assign frame_count   = r_frame_count;
  assign playing       = r_playing;
  assign fault         = r_fault;

endmodule

// File: tb/tb_playback_scheduler.sv
// ---------------------------------------------------------------------------
// tb_playback_scheduler
//
// Randomized scoreboard bench for playback_scheduler. A behavioural model of
// the playback rules predicts every visible event (fetch request, frame
// advance, underrun, playing/fault change) with its cycle stamp and the bank
// state after it; a monitor compares each DUT event against the queue.
// Honours LOOP_PLAYBACK_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_playback_scheduler;

  localparam int REP = 2;
  localparam int NF  = 4;
  localparam int FW  = 3;
  localparam int TO  = 100;

  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_PLAY  = 2;
  localparam int M_FAULT = 3;

  logic          CLK_40 = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          vsync_pulse = 1'b0;
  logic          fetch_done = 1'b0;
  logic          fetch_req;
  logic          wr_sel;
  logic          rd_sel;
  logic [1:0]    bank_valid;
  logic          frame_advance;
  logic          underrun;
  logic [FW-1:0] frame_count;
  logic          playing;
  logic          fault;

  always #5 CLK_40 = ~CLK_40;

  playback_scheduler #(
    .FRAME_REPEAT   (REP),
    .NUM_FRAMES     (NF),
    .FRAME_CNT_W    (FW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK_40        (CLK_40),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .vsync_pulse   (vsync_pulse),
    .fetch_done    (fetch_done),
    .fetch_req     (fetch_req),
    .wr_sel        (wr_sel),
    .rd_sel        (rd_sel),
    .bank_valid    (bank_valid),
    .frame_advance (frame_advance),
    .underrun      (underrun),
    .frame_count   (frame_count),
    .playing       (playing),
    .fault         (fault)
  );

  typedef struct packed {
    int unsigned cyc;
    logic        req;
    logic        adv;
    logic        und;
    logic        play;
    logic        flt;
    logic [1:0]  bv;
    logic        wr;
    logic        rd;
    logic [FW-1:0] fc;
  } ev_t;

  ev_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc = 0;

  always @(posedge CLK_40) cyc <= cyc + 1;

  function automatic string ev_str(input ev_t e);
    return $sformatf("cyc=%0d req=%0b adv=%0b und=%0b play=%0b flt=%0b bv=%b wr=%0b rd=%0b fc=%0d",
                     e.cyc, e.req, e.adv, e.und, e.play, e.flt, e.bv, e.wr, e.rd, e.fc);
  endfunction

  // ---------------- behavioural reference model ----------------
  int       m_mode;
  bit [1:0] m_valid;
  bit       m_wr, m_rd, m_busy, m_sprev, m_pplay, m_pflt, m_req;
  int       m_age, m_vs, m_fc;
  int       cov_adv = 0, cov_und = 0, cov_flt = 0, cov_eos = 0, cov_coinc = 0;

  function automatic void idle_clear();
    m_mode = M_IDLE; m_valid = 2'b00; m_busy = 0; m_wr = 0; m_rd = 0;
    m_fc = 0; m_vs = 0; m_age = 0;
  endfunction

  function automatic void model_init();
    idle_clear();
    m_sprev = 0; m_pplay = 0; m_pflt = 0; m_req = 0;
  endfunction

  // Advances the model by one clock given the inputs sampled at that edge.
  task automatic model_step(input bit st, input bit sp, input bit vs, input bit fd);
    bit rise, acc, adv, und, play, flt;
    bit [1:0] v0;
    ev_t e;
    rise = st && !m_sprev;
    m_sprev = st;
    m_req = 0; adv = 0; und = 0;
    if (sp) idle_clear();
    else if (m_mode == M_IDLE) begin
      if (rise) m_mode = M_PRIME;
    end else if (m_mode == M_FAULT) begin
      if (rise) idle_clear();
    end else if (m_busy && m_age == TO - 1) begin
      m_mode = M_FAULT; m_age = 0; cov_flt++;
    end else begin
      v0  = m_valid;
      acc = fd && m_busy;
      if (acc) begin
        m_valid[m_wr] = 1'b1; m_wr = !m_wr; m_busy = 0; m_age = 0;
      end else if (m_busy) m_age++;
      else if (!v0[m_wr]) begin
        m_req = 1; m_busy = 1; m_age = 0;
      end
      if (m_mode == M_PRIME) begin
        if (vs && v0 == 2'b11) begin
          m_mode = M_PLAY; m_vs = 0; m_rd = 0; m_fc = 0;
        end
      end else if (vs) begin
        if (m_vs < REP - 1) m_vs++;
        else begin
          m_vs = 0;
          if (v0[!m_rd]) begin
            if (m_fc == NF - 1) begin
              cov_eos++;
`ifdef LOOP_PLAYBACK_EN
              m_valid[m_rd] = 1'b0; m_rd = !m_rd; m_fc = 0; adv = 1;
`else
              idle_clear();
`endif
            end else begin
              m_valid[m_rd] = 1'b0; m_rd = !m_rd; m_fc++; adv = 1;
            end
          end else begin
            und = 1;
            if (acc) cov_coinc++;
          end
        end
      end
    end
    play = (m_mode == M_PLAY);
    flt  = (m_mode == M_FAULT);
    if (m_req || adv || und || play != m_pplay || flt != m_pflt) begin
      e = '{cyc + 1, m_req, adv, und, play, flt, m_valid, m_wr, m_rd, FW'(m_fc)};
      exp_q.push_back(e);
    end
    m_pplay = play; m_pflt = flt;
    if (adv) cov_adv++;
    if (und) cov_und++;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic pp, pf;
    ev_t  got, want;
    pp = 0; pf = 0;
    forever begin
      @(negedge CLK_40);
      if (reset) begin
        pp = 0; pf = 0;
        continue;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        want = exp_q.pop_front();
        n_tests++; n_fail++;
        $display("FAIL missing_event: got no output event, required %s", ev_str(want));
      end
      if (fetch_req || frame_advance || underrun || playing != pp || fault != pf) begin
        got = '{cyc, fetch_req, frame_advance, underrun, playing, fault,
                bank_valid, wr_sel, rd_sel, frame_count};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got %s, required no event", ev_str(got));
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL event: got %s, required %s", ev_str(got), ev_str(want));
          end
        end
      end
      pp = playing; pf = fault;
    end
  end

  // ---------------- stimulus ----------------
  int fd_cnt = 0;
  int vs_cnt = 8;
  int st_hold = 0;

  function automatic int pick_latency(input int kind);
    int r;
    if (kind == 0) return 10;
    r = $urandom_range(0, 99);
    if (r < 3)  return 150;                          // beyond the watchdog
    if (r < 20) return $urandom_range(25, 45);        // slow: provokes underrun
    return $urandom_range(1, 15);
  endfunction

  // kind 0: directed bring-up, 1: random, 2: stop held
  task automatic run_phase(input int ncyc, input int kind);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge CLK_40); #2;
      reset = 1'b0; vsync_pulse = 1'b0; fetch_done = 1'b0; stop = 1'b0;
      if (kind == 2) begin
        stop = 1'b1; start = 1'b0;
      end else begin
        if (vs_cnt <= 1) begin
          vsync_pulse = 1'b1;
          vs_cnt = (kind == 0) ? 8 : $urandom_range(6, 12);
        end else vs_cnt--;
        if (fd_cnt > 0) begin
          fd_cnt--;
          if (fd_cnt == 0) fetch_done = 1'b1;
        end
        if (kind == 1) begin
          if (vsync_pulse && m_mode == M_PLAY && m_busy && m_vs == REP - 1 &&
              fd_cnt > 0 && $urandom_range(0, 1) == 1) begin
            fetch_done = 1'b1; fd_cnt = 0;
          end
          if (!m_busy && $urandom_range(0, 19) == 0) fetch_done = 1'b1;
          if (st_hold > 0) begin
            start = 1'b1; st_hold--;
          end else begin
            start = 1'b0;
            if ((m_mode == M_IDLE || m_mode == M_FAULT) && $urandom_range(0, 29) == 0)
              st_hold = $urandom_range(1, 4);
          end
          if ($urandom_range(0, 399) == 0) stop = 1'b1;
        end else begin
          start = (i == 2 || i == 3);
        end
      end
      model_step(start, stop, vsync_pulse, fetch_done);
      if (m_req) fd_cnt = pick_latency(kind);
    end
  endtask

  task automatic do_reset_check(input string tag);
    @(posedge CLK_40); #2;
    reset = 1'b1; start = 1'b0; stop = 1'b0; vsync_pulse = 1'b0; fetch_done = 1'b0;
    repeat (3) @(posedge CLK_40);
    @(negedge CLK_40);
    n_tests++;
    if ({fetch_req, wr_sel, rd_sel, bank_valid, frame_advance, underrun,
         frame_count, playing, fault} !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs=%b required all zero", tag,
               {fetch_req, wr_sel, rd_sel, bank_valid, frame_advance, underrun,
                frame_count, playing, fault});
    end
    exp_q.delete();
    model_init();
    fd_cnt = 0; st_hold = 0; vs_cnt = 8;
  endtask

  task automatic cover_check(input string name, input int cnt);
    n_tests++;
    if (cnt == 0) begin
      n_fail++;
      $display("FAIL cover_%s: count=%0d required >0", name, cnt);
    end
  endtask

  initial begin : main
    model_init();
    do_reset_check("reset_state");
    run_phase(200, 0);
    run_phase(15000, 1);
    do_reset_check("reset_midrun");
    run_phase(4000, 1);
    run_phase(5, 2);
    repeat (2) @(negedge CLK_40);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d events outstanding, required 0", exp_q.size());
    end
    cover_check("advance", cov_adv);
    cover_check("underrun", cov_und);
    cover_check("fault", cov_flt);
    cover_check("end_of_stream", cov_eos);
    cover_check("coincident_done", cov_coinc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
